l2_ch_arbiter: RTL
==================

# l2_ch_arbiter

Two-requester arbiter and sequencer in front of the shared L2 cache access port (`l2_ch_*`). It serialises accesses from the instruction-side (port 0) and data-side (port 1) L1 miss handlers, and injects cache-flush requests. It holds exactly one downstream transaction outstanding and returns read data or write completion to the winning port. It sits between the L1 caches and the L2 cache in the `clk` domain.

## Interface
- `AW`, 25: byte address width.
- `DW`, 32: data width (only 32 is supported).
- `FLUSH_HOLD`, 4: minimum cycles, counted from the `m_flush` pulse, before flush completion may be reported.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pN_req`  in  1  port N request (N=0,1); held with its fields until `pN_ack`.
- `pN_addr`  in  AW  port N byte address.
- `pN_din`  in  DW  port N write data.
- `pN_size_msk`  in  4  port N byte-write mask; 0 = read.
- `pN_ack`  out  1  one-cycle pulse: request N latched.
- `pN_vld`  out  1  one-cycle pulse: response N complete, `pN_dout` valid.
- `pN_dout`  out  DW  port N read data.
- `flush_req`  in  1  one-cycle flush request pulse.
- `flush_done`  out  1  one-cycle pulse: flush completed.
- `m_addr`  out  AW  to L2 address.
- `m_din`  out  DW  to L2 write data.
- `m_size_msk`  out  4  to L2 write mask.
- `m_req`  out  1  to L2 request.
- `m_flush`  out  1  to L2 flush pulse.
- `m_ready`  in  1  from L2 ready.
- `m_dout`  in  DW  from L2 read data.

## Operation
- All outputs are registered.
- Reset values are 0 for every output, plus the following state:
  - `state=S_IDLE`.
  - `rr_last=1`, so port 0 wins the first tie.
  - `flush_pend=0`, `gnt=0`, `fcnt=0`.
- `flush_pend` is set by `flush_req`. It is cleared when `m_flush` is issued.
- **S_IDLE** selects, in priority order:
  1. `flush_pend` → `m_flush<=1` for 1 cycle, `fcnt<=0`, go to S_FLUSH.
  2. Exactly one `pN_req` → grant N.
  3. Both requests → grant N != `rr_last`.
- **Grant** does the following on the same edge:
  - `m_addr`, `m_din` and `m_size_msk` are latched from port N.
  - `m_req<=1`, `pN_ack<=1`, `gnt<=N`, `rr_last<=N`.
  - Go to S_ISSUE.
- **S_ISSUE** holds `m_req` until an edge where `m_ready=1` (the L2 accepts).
  - On that edge `m_req<=0`; go to S_WAIT.
- **S_WAIT** waits for the first cycle after acceptance with `m_ready=1`. On that edge:
  - `pgnt_dout<=m_dout` and `pgnt_vld<=1`.
  - `m_size_msk<=0`.
  - Go to S_IDLE.
  - Writes get `vld` too; `dout` is don't-care for writes.
- **S_FLUSH**: `fcnt` increments, saturating at `FLUSH_HOLD`.
  - When `fcnt==FLUSH_HOLD` and `m_ready=1`: `flush_done<=1`, go to S_IDLE.
- `pN_dout` holds its last value until the next `pN_vld`.
- A `flush_req` arriving in any state is remembered, and two pulses before service merge into one flush.
- A `flush_req` arriving on the same edge `flush_pend` clears (`m_flush` issue) sets `flush_pend` again, giving a second flush.
- Reset mid-transaction aborts the transaction, with no `vld`. The requester reissues.

## Timing
- Minimum hit latency, `pN_req` rising in cycle T with the L2 idle and ready:
  - `pN_ack` and `m_req` are high in T+1.
  - The L2 accepts at the end of T+1.
  - `pN_vld` is high in T+3, when `m_ready` stays 1.
- Back-to-back: the next grant is evaluated in the cycle `vld` is high. Maximum throughput is 1 access per 3 cycles.
- Requester rule: `req` may drop only after `ack`. An `ack`ed requester may keep `req` high for its next access; it is re-arbitrated normally.
- `m_req` deasserts exactly on the accept edge, so the L2 never sees a duplicate request.
- `m_flush` is never high while `m_req` is high or a transaction is outstanding.
- Flush completion takes at least `FLUSH_HOLD`+1 cycles after the `m_flush` cycle. It extends for as long as the L2 holds `m_ready=0`.

## Test plan
- **Single read:** `p0_req`, addr 0x0000040, L2 model hit, `m_dout`=0xDEADBEEF.
  - Expect `p0_ack` at T+1, `m_req` for 1 cycle.
  - Expect `p0_vld` at T+3 with `p0_dout`=0xDEADBEEF.
- **Tie round-robin:** both ports request continuously, 4 accesses each.
  - Grants go 0,1,0,1…; each port gets exactly 4 `vld`s.
  - `p1_dout` is never corrupted by port 0 data.
- **Miss stall:** the L2 model drops `m_ready` for 20 cycles after acceptance.
  - `vld` arrives on the first `m_ready=1` cycle afterwards.
  - `m_req` stays 0 throughout the stall.
- **Write:** `p1_size_msk`=4'b0011, `din`=0x12345678.
  - `m_size_msk`=0011 and `m_din` match during `m_req`.
  - `p1_vld` pulses; `m_size_msk` returns to 0.
- **Flush priority:** `flush_req` during an outstanding port 0 read, with `p1_req` pending.
  - The read completes first, then `m_flush` pulses.
  - `flush_done` fires at or after `FLUSH_HOLD`+1 cycles and only once `m_ready=1`.
  - Port 1 is granted only after `flush_done`.
- **Reset mid-S_WAIT:** all outputs go to 0 immediately (asynchronous).
  - After release, a new `p0_req` is granted in 1 cycle.
  - No stale `vld` appears.

Source files
------------

// File: rtl/l2_ch_arbiter_if.sv
// Bundle between the two L1 miss handlers, the flush source and the shared L2
// access port; the arbiter takes the slave view, the environment the master view.
interface l2_ch_arbiter_if #(
  parameter int unsigned AW = 25,
  parameter int unsigned DW = 32
);
  logic          p0_req;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_din;
  logic [3:0]    p0_size_msk;
  logic          p0_ack;
  logic          p0_vld;
  logic [DW-1:0] p0_dout;

  logic          p1_req;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_din;
  logic [3:0]    p1_size_msk;
  logic          p1_ack;
  logic          p1_vld;
  logic [DW-1:0] p1_dout;

  logic          flush_req;
  logic          flush_done;

  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [3:0]    m_size_msk;
  logic          m_req;
  logic          m_flush;
  logic          m_ready;
  logic [DW-1:0] m_dout;

  modport slave (
    input  p0_req, p0_addr, p0_din, p0_size_msk,
    output p0_ack, p0_vld, p0_dout,
    input  p1_req, p1_addr, p1_din, p1_size_msk,
    output p1_ack, p1_vld, p1_dout,
    input  flush_req,
    output flush_done,
    output m_addr, m_din, m_size_msk, m_req, m_flush,
    input  m_ready, m_dout
  );

  modport master (
    output p0_req, p0_addr, p0_din, p0_size_msk,
    input  p0_ack, p0_vld, p0_dout,
    output p1_req, p1_addr, p1_din, p1_size_msk,
    input  p1_ack, p1_vld, p1_dout,
    output flush_req,
    input  flush_done,
    input  m_addr, m_din, m_size_msk, m_req, m_flush,
    output m_ready, m_dout
  );
endinterface

// File: rtl/l2_ch_arbiter.sv
// Round-robin arbiter and sequencer for the shared L2 port: one transaction
// outstanding at a time, flush injection with a minimum hold before completion.
module l2_ch_arbiter #(
  parameter int unsigned AW         = 25,
  parameter int unsigned DW         = 32,
  parameter int unsigned FLUSH_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  l2_ch_arbiter_if.slave     bus
);

  localparam int unsigned FCW = $clog2(FLUSH_HOLD + 1);
  localparam logic [FCW-1:0] FCNT_MAX = FCW'(FLUSH_HOLD);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]     state_q, state_d;
  logic           rr_last_q, rr_last_d;
  logic           flush_pend_q, flush_pend_d;
  logic           gnt_q, gnt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;

  logic [AW-1:0]  m_addr_q, m_addr_d;
  logic [DW-1:0]  m_din_q, m_din_d;
  logic [3:0]     m_size_msk_q, m_size_msk_d;
  logic           m_req_q, m_req_d;
  logic           m_flush_q, m_flush_d;

  logic           p0_ack_q, p0_ack_d;
  logic           p1_ack_q, p1_ack_d;
  logic           p0_vld_q, p0_vld_d;
  logic           p1_vld_q, p1_vld_d;
  logic [DW-1:0]  p0_dout_q, p0_dout_d;
  logic [DW-1:0]  p1_dout_q, p1_dout_d;
  logic           flush_done_q, flush_done_d;

  logic           sel;

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_last_q    <= 1'b1;
      flush_pend_q <= 1'b0;
      gnt_q        <= 1'b0;
      fcnt_q       <= '0;
      m_addr_q     <= '0;
      m_din_q      <= '0;
      m_size_msk_q <= '0;
      m_req_q      <= 1'b0;
      m_flush_q    <= 1'b0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_vld_q     <= 1'b0;
      p1_vld_q     <= 1'b0;
      p0_dout_q    <= '0;
      p1_dout_q    <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      flush_pend_q <= flush_pend_d;
      gnt_q        <= gnt_d;
      fcnt_q       <= fcnt_d;
      m_addr_q     <= m_addr_d;
      m_din_q      <= m_din_d;
      m_size_msk_q <= m_size_msk_d;
      m_req_q      <= m_req_d;
      m_flush_q    <= m_flush_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_vld_q     <= p0_vld_d;
      p1_vld_q     <= p1_vld_d;
      p0_dout_q    <= p0_dout_d;
      p1_dout_q    <= p1_dout_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    flush_pend_d = flush_pend_q | bus.flush_req;
    gnt_d        = gnt_q;
    fcnt_d       = fcnt_q;
    m_addr_d     = m_addr_q;
    m_din_d      = m_din_q;
    m_size_msk_d = m_size_msk_q;
    m_req_d      = m_req_q;
    m_flush_d    = 1'b0;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p0_vld_d     = 1'b0;
    p1_vld_d     = 1'b0;
    p0_dout_d    = p0_dout_q;
    p1_dout_d    = p1_dout_q;
    flush_done_d = 1'b0;
    sel          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flush_pend_q) begin
          // A request on this same edge re-arms the pending flag for a second flush.
          m_flush_d    = 1'b1;
          fcnt_d       = '0;
          flush_pend_d = bus.flush_req;
          state_d      = S_FLUSH;
        end else if (bus.p0_req || bus.p1_req) begin
          sel       = (bus.p0_req && bus.p1_req) ? ~rr_last_q : bus.p1_req;
          gnt_d     = sel;
          rr_last_d = sel;
          m_req_d   = 1'b1;
          state_d   = S_ISSUE;
          if (sel) begin
            m_addr_d     = bus.p1_addr;
            m_din_d      = bus.p1_din;
            m_size_msk_d = bus.p1_size_msk;
            p1_ack_d     = 1'b1;
          end else begin
            m_addr_d     = bus.p0_addr;
            m_din_d      = bus.p0_din;
            m_size_msk_d = bus.p0_size_msk;
            p0_ack_d     = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        if (bus.m_ready) begin
          m_req_d = 1'b0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.m_ready) begin
          if (gnt_q) begin
            p1_dout_d = bus.m_dout;
            p1_vld_d  = 1'b1;
          end else begin
            p0_dout_d = bus.m_dout;
            p0_vld_d  = 1'b1;
          end
          m_size_msk_d = 4'd0;
          state_d      = S_IDLE;
        end
      end

      S_FLUSH: begin
        // Hold count saturates so a stalled L2 simply extends the flush.
        if (fcnt_q != FCNT_MAX) begin
          fcnt_d = fcnt_q + FCW'(1);
        end else if (bus.m_ready) begin
          flush_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.p0_ack     = p0_ack_q;
  assign bus.p1_ack     = p1_ack_q;
  assign bus.p0_vld     = p0_vld_q;
  assign bus.p1_vld     = p1_vld_q;
  assign bus.p0_dout    = p0_dout_q;
  assign bus.p1_dout    = p1_dout_q;
  assign bus.flush_done = flush_done_q;
  assign bus.m_addr     = m_addr_q;
  assign bus.m_din      = m_din_q;
  assign bus.m_size_msk = m_size_msk_q;
  assign bus.m_req      = m_req_q;
  assign bus.m_flush    = m_flush_q;

endmodule
